// File: rtl/fm_rx_pkg.sv
// Shared width constants and sizing helper for the FM receiver FIR tap arithmetic.
package fm_rx_pkg;

  localparam int COEFF_W   = 16;
  localparam int SAMPLE_W  = 16;
  localparam int ACC_W     = 30;
  localparam int FRAC_BITS = 14;

  // One guard bit above the wider of product and addend so the sum never overflows internally.
  function automatic int sum_width(input int prod_w, input int add_w);
    return ((prod_w > add_w) ? prod_w : add_w) + 1;
  endfunction

endpackage

// File: rtl/fm_rx_pipe_reg.sv
// Width-parameterised pipeline register with synchronous active-low clear and clock enable.
module fm_rx_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else if (ce) q <= d;
  end

endmodule

// File: rtl/fm_rx_mbkb_muladd.sv
// Signed multiply-add dout = din0*din1 + din2 with NUM_STAGE-1 pipeline registers.
// Optional saturation of the result is enabled by FM_RX_MBKB_MULADD_SATURATE_EN.
module fm_rx_mbkb_muladd
  import fm_rx_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 1,
  parameter int din0_WIDTH = COEFF_W,
  parameter int din1_WIDTH = SAMPLE_W,
  parameter int din2_WIDTH = ACC_W,
  parameter int dout_WIDTH = ACC_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [din2_WIDTH-1:0] din2,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int PROD_W    = din0_WIDTH + din1_WIDTH;
  localparam int SUM_W     = sum_width(PROD_W, din2_WIDTH);
  localparam int unused_id = ID;

  logic [din0_WIDTH-1:0] op_a;
  logic [din1_WIDTH-1:0] op_b;
  logic [din2_WIDTH-1:0] op_c;
  logic [PROD_W-1:0]     a_ext, b_ext, prod;
  logic [PROD_W-1:0]     prod_s;
  logic [din2_WIDTH-1:0] add_s;
  logic [SUM_W-1:0]      sum, sum_s;

  generate
    if (NUM_STAGE == 1) begin : g_op_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{ap_clk, ap_rst_n, ce};
      assign op_a = din0;
      assign op_b = din1;
      assign op_c = din2;
    end else begin : g_op_reg
      fm_rx_pipe_reg #(.WIDTH(din0_WIDTH + din1_WIDTH + din2_WIDTH)) u_stage1 (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .ce    (ce),
        .d     ({din0, din1, din2}),
        .q     ({op_a, op_b, op_c})
      );
    end
  endgenerate

  // Sign-extend to full product width; low PROD_W bits of the unsigned product are exact.
  assign a_ext = {{din1_WIDTH{op_a[din0_WIDTH-1]}}, op_a};
  assign b_ext = {{din0_WIDTH{op_b[din1_WIDTH-1]}}, op_b};
  assign prod  = a_ext * b_ext;

  generate
    if (NUM_STAGE <= 2) begin : g_prod_comb
      assign prod_s = prod;
      assign add_s  = op_c;
    end else begin : g_prod_reg
      fm_rx_pipe_reg #(.WIDTH(PROD_W + din2_WIDTH)) u_stage2 (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .ce    (ce),
        .d     ({prod, op_c}),
        .q     ({prod_s, add_s})
      );
    end
  endgenerate

  assign sum = {{(SUM_W - PROD_W){prod_s[PROD_W-1]}}, prod_s}
             + {{(SUM_W - din2_WIDTH){add_s[din2_WIDTH-1]}}, add_s};

  generate
    if (NUM_STAGE <= 3) begin : g_sum_comb
      assign sum_s = sum;
    end else begin : g_sum_reg
      logic [SUM_W-1:0] chain [0:NUM_STAGE-3];
      assign chain[0] = sum;
      for (genvar i = 0; i < NUM_STAGE - 3; i++) begin : g_stage
        fm_rx_pipe_reg #(.WIDTH(SUM_W)) u_sum (
          .clk   (ap_clk),
          .rst_n (ap_rst_n),
          .ce    (ce),
          .d     (chain[i]),
          .q     (chain[i+1])
        );
      end
      assign sum_s = chain[NUM_STAGE-3];
    end
  endgenerate

`ifdef FM_RX_MBKB_MULADD_SATURATE_EN
  // In range only when every bit from the result sign bit upward agrees.
  logic in_range;
  assign in_range = (sum_s[SUM_W-1:dout_WIDTH-1] == '0) || (sum_s[SUM_W-1:dout_WIDTH-1] == '1);
  always_comb begin
    dout = sum_s[dout_WIDTH-1:0];
    if (!in_range) dout = {sum_s[SUM_W-1], {(dout_WIDTH-1){~sum_s[SUM_W-1]}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum_s[SUM_W-1:dout_WIDTH];
  assign dout = sum_s[dout_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_fm_rx_mbkb_muladd.sv
// Directed bench: combinational (NUM_STAGE=1) and 3-stage pipelined instances side by side.
module tb_fm_rx_mbkb_muladd;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [15:0] a1, b1, a3, b3;
  logic [29:0] c1, c3;
  logic [29:0] dout1, dout3;

  int checks = 0;
  int errors = 0;

  fm_rx_mbkb_muladd #(.ID(1), .NUM_STAGE(1)) u_n1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce),
    .din0(a1), .din1(b1), .din2(c1), .dout(dout1)
  );

  fm_rx_mbkb_muladd #(.ID(2), .NUM_STAGE(3)) u_n3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce),
    .din0(a3), .din1(b3), .din2(c3), .dout(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic comb(input logic [15:0] a, input logic [15:0] b, input logic [29:0] c);
    a1 = a; b1 = b; c1 = c;
    #1;
  endtask

  task automatic drive3(input logic [15:0] a, input logic [15:0] b, input logic [29:0] c);
    a3 = a; b3 = b; c3 = c;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1;
    a1 = '0; b1 = '0; c1 = '0;
    a3 = 16'h1234; b3 = 16'h0005; c3 = 30'h0000_0009;

    // Combinational instance
    comb(16'h4000, 16'h2000, 30'h0);         check("n1_half",     dout1, 30'h0800_0000);
    comb(16'hFFFF, 16'h0003, 30'd10);        check("n1_neg",      dout1, 30'h0000_0007);
    comb(16'h0000, 16'h0000, 30'h2000_0000); check("n1_addmin",   dout1, 30'h2000_0000);
    comb(16'hFFFF, 16'hFFFF, 30'h3FFF_FFFF); check("n1_cancel",   dout1, 30'h0000_0000);
`ifdef FM_RX_MBKB_MULADD_SATURATE_EN
    comb(16'h8000, 16'h8000, 30'h0);         check("n1_sat_pos",  dout1, 30'h1FFF_FFFF);
    comb(16'h7FFF, 16'h8000, 30'h0);         check("n1_sat_neg",  dout1, 30'h2000_0000);
`else
    comb(16'h8000, 16'h8000, 30'h0);         check("n1_wrap_pos", dout1, 30'h0000_0000);
    comb(16'h7FFF, 16'h8000, 30'h0);         check("n1_wrap_neg", dout1, 30'h0000_8000);
`endif

    // Pipelined instance: reset clears everything
    tick(); tick();
    check("n3_reset", dout3, 30'h0);
    rst_n = 1'b1;
    drive3(16'h4000, 16'h4000, 30'h0000_4000);
    tick();
    drive3(16'h0001, 16'h0001, 30'h0);
    tick();
    check("n3_first", dout3, 30'h1000_4000);
    drive3(16'h0002, 16'h0003, 30'd5);
    tick();
    check("n3_second", dout3, 30'h0000_0001);
    drive3(16'hFFFF, 16'h0002, 30'h0);

    // Stall for three edges; output must hold
    ce = 1'b0;
    tick(); check("n3_hold0", dout3, 30'h0000_0001);
    tick(); check("n3_hold1", dout3, 30'h0000_0001);
    tick(); check("n3_hold2", dout3, 30'h0000_0001);
    ce = 1'b1;
    tick();
    check("n3_resume0", dout3, 30'd11);
    drive3(16'h0003, 16'h0003, 30'd1);
    tick();
    check("n3_resume1", dout3, 30'h3FFF_FFFE);

    // Reset with (3,3,1) in flight: it must never appear
    drive3(16'h0004, 16'h0004, 30'h0);
    rst_n = 1'b0;
    tick();
    check("n3_midreset", dout3, 30'h0);
    rst_n = 1'b1;
    drive3(16'h0005, 16'h0005, 30'd5);
    tick();
    check("n3_flushed", dout3, 30'h0);
    drive3(16'h0000, 16'h0000, 30'd7);
    tick();
    check("n3_after_rst0", dout3, 30'd30);
    tick();
    check("n3_after_rst1", dout3, 30'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_rx_mbkb_muladd.md
Name: fm_rx_mbkb_muladd

Overview:
- Signed multiply-add: dout = din0*din1 + din2, truncated to dout_WIDTH.
- The FM receiver's FIR tap operator uses it for the tap accumulation step: coeff × shift-register sample + (accumulator << 14).
- Implements the fm_receiver_hls_mbkb macro.
- The pipeline depth is configurable.
- With NUM_STAGE=1 it is purely combinational, which is the depth the FIR operator uses.

Parameters:
- ID, 1, instance identifier; has no functional effect.
- NUM_STAGE, 1, total latency stages. 1 = combinational. N>1 = N-1 register stages.
- din0_WIDTH, 16, width of the signed multiplicand (coefficient, Q2.14).
- din1_WIDTH, 16, width of the signed multiplier (sample, Q2.14).
- din2_WIDTH, 30, width of the signed addend (accumulator pre-shifted by 14).
- dout_WIDTH, 30, width of the signed result.

Ports:
- ap_clk, in, 1, clock. Rising edge.
- ap_rst_n, in, 1, reset. Synchronous, active-low.
- ce, in, 1, clock enable for the pipeline registers. Ignored when NUM_STAGE=1.
- din0, in, din0_WIDTH, signed multiplicand.
- din1, in, din1_WIDTH, signed multiplier.
- din2, in, din2_WIDTH, signed addend.
- dout, out, dout_WIDTH, signed result (low dout_WIDTH bits).

Behaviour:
- Arithmetic: all operands are two's complement.
  - Product is full precision: din0_WIDTH+din1_WIDTH bits.
  - din2 is sign-extended.
  - Sum is formed at max(product width, din2_WIDTH)+1 bits.
  - dout = low dout_WIDTH bits of the sum. Overflow wraps (modulo 2^dout_WIDTH).
- NUM_STAGE=1:
  - dout is a pure combinational function of din0, din1 and din2; latency 0.
  - ap_clk, ap_rst_n and ce have no effect.
  - No registers are inferred.
- NUM_STAGE=N>1: there are N-1 registers.
  - Stage 1 registers the operands.
  - Stage 2 registers the product and the delayed din2.
  - Any further stages register the sum (sum stages are extra output delay).
  - On a rising edge with ce=1, every stage advances.
  - Latency is N-1 enabled edges from inputs to dout. No bubbles; throughput is 1 per cycle.
  - ce=0: all stages hold their contents and dout is stable.
- Reset, N>1:
  - When ap_rst_n=0 at a rising edge, all stage registers clear to 0, so dout=0 on the next cycle.
  - Reset takes priority over ce.
  - Reset mid-pipeline discards in-flight results.
  - The first valid result appears N-1 enabled edges after the first input following reset release.
- No handshake. The caller schedules by fixed latency.

Optional Feature:
- Macro: FM_RX_MBKB_MULADD_SATURATE_EN.
- Defined:
  - The full-precision sum saturates to the signed dout_WIDTH range instead of wrapping.
  - Defaults 30-bit: max = 0x1FFFFFFF, min = 0x20000000.
  - Saturation is applied in the last stage (combinationally when N=1).
- Undefined: wrap-around truncation as in Behaviour.

Decomposition:
- Package fm_rx_pkg holds:
  - the default width constants (COEFF_W=16, SAMPLE_W=16, ACC_W=30, FRAC_BITS=14);
  - a helper function for the full-precision sum width.
- One natural sub-module, fm_rx_pipe_reg: a width-parameterised register with synchronous active-low clear and ce. It is instantiated per stage.
- The arithmetic stays inline.

Test Plan:
- N=1: din0=0x4000, din1=0x2000, din2=0 -> dout=0x08000000 (dout[29:14]=0x2000, i.e. 1.0×0.5).
- N=1: din0=0xFFFF(-1), din1=3, din2=10 -> dout=0x0000007. Separately, din0=din1=0, din2=0x20000000 -> dout=0x20000000.
- N=1 wrap: din0=din1=0x8000, din2=0 -> dout=0x0000000. With SATURATE_EN: dout=0x1FFFFFFF.
- N=3, ce=1: apply (0x4000, 0x4000, 0x0004000) then (1, 1, 0) on consecutive cycles.
  - dout=0x10004000 two edges after the first input.
  - dout=0x0000001 on the following edge.
- N=3: hold ce=0 for 3 cycles mid-stream -> dout frozen. Results resume in order once ce=1.
- N=3: drive ap_rst_n=0 for one edge with data in flight -> dout=0 next cycle. The in-flight result is never emitted; new results resume after 2 enabled edges.
